// File: rtl/tdc_sequencer.sv
// tdc_sequencer: run controller for the tapped-delay-line TDC core.
// It arms the core, captures each timestamp into a first-word-fall-through
// FIFO, then resets and re-arms the core until the programmed number of
// measurements has completed.
// Optional feature: define TDC_TIMEOUT_EN to add a per-measurement WAIT
// timeout (TMO_W-bit counter) and a saturating timeout count on oTimeouts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no run; core held in reset, waiting for iStart
// S_GAP   | core held in reset for the inter-measurement gap
// S_WAIT  | core enabled, waiting for its done (or for the timeout)
// S_STORE | capture register written to the FIFO, measurement counted

`ifndef DIG_OUT
`define DIG_OUT 8
`endif

module tdc_sequencer #(
  parameter int DATA_W  = `DIG_OUT,
  parameter int CNT_W   = 16,
  parameter int FIFO_AW = 4,
  parameter int GAP_CYC = 4,
  parameter int TMO_W   = 12
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic [CNT_W-1:0]  iNumMeas,
  input  logic [DATA_W-1:0] iTdcData,
  input  logic              iTdcDone,
  output logic              oTdcEnable,
  output logic              oTdcRst,
  input  logic              iRd,
  output logic [DATA_W-1:0] oData,
  output logic              oEmpty,
  output logic              oFull,
  output logic [FIFO_AW:0]  oLevel,
  output logic              oBusy,
  output logic              oRunDone,
  output logic              oOverflow,
  output logic [CNT_W-1:0]  oRemaining,
  output logic [CNT_W-1:0]  oTimeouts
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [FIFO_AW:0] DEPTH_L  = DEPTH[FIFO_AW:0];
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

  // Parameter sanity: the gap must exist and the timeout counter needs room.
  if (GAP_CYC < 1 || TMO_W < 2) begin : g_param_check
    $error("tdc_sequencer: GAP_CYC must be >= 1 and TMO_W >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_WAIT, S_STORE} state_t;

  state_t              state;
  logic [GAP_W-1:0]    gap_cnt;
  logic [DATA_W-1:0]   cap_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    level;
  logic                pop;
  logic                push;
  logic                last_meas;
  logic [CNT_W-1:0]    rem_dec;

  // {enable, core reset, busy} as seen by the core and host in each state.
  // STORE already drops enable and starts the core's reset.
  function automatic logic [2:0] drive_for(state_t s);
    case (s)
      S_WAIT:  return 3'b101;
      S_IDLE:  return 3'b010;
      default: return 3'b011;
    endcase
  endfunction

  assign oEmpty = (level == '0);
  assign oFull  = (level == DEPTH_L);
  assign oLevel = level;
  assign oData  = mem[rd_ptr];

  // An abort in STORE discards the pending write along with the rest of the run.
  assign pop  = iRd && !oEmpty;
  assign push = (state == S_STORE) && !iAbort && (!oFull || pop);

  // A dropped or timed-out result still counts; never wrap below zero.
  assign last_meas = (oRemaining <= CNT_W'(1));
  assign rem_dec   = last_meas ? '0 : oRemaining - 1'b1;

`ifdef TDC_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] timeouts_q;
  assign oTimeouts = timeouts_q;
`else
  assign oTimeouts = '0;
`endif

  // FIFO pointer and level bookkeeping; reset empties the FIFO.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr] <= cap_q;
  end

  // Sequencer FSM with registered core controls and run status.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      cap_q      <= '0;
      oTdcEnable <= 1'b0;
      oTdcRst    <= 1'b1;
      oBusy      <= 1'b0;
      oRunDone   <= 1'b0;
      oOverflow  <= 1'b0;
      oRemaining <= '0;
`ifdef TDC_TIMEOUT_EN
      tmo_cnt    <= '0;
      timeouts_q <= '0;
`endif
    end else begin
      oRunDone <= 1'b0;
      if (state != S_IDLE && iAbort) begin
        state <= S_IDLE;
        {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_IDLE);
      end else begin
        case (state)
          S_IDLE: begin
            if (iStart) begin
              if (iNumMeas != '0) begin
                oRemaining <= iNumMeas;
                oOverflow  <= 1'b0;
`ifdef TDC_TIMEOUT_EN
                timeouts_q <= '0;
`endif
                gap_cnt <= GAP_LOAD;
                state   <= S_GAP;
                {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_GAP);
              end else begin
                oRunDone <= 1'b1;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) begin
              state <= S_WAIT;
              {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_WAIT);
`ifdef TDC_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          S_WAIT: begin
            if (iTdcDone) begin
              cap_q <= iTdcData;
              state <= S_STORE;
              {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_STORE);
            end
`ifdef TDC_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
              if (timeouts_q != '1) timeouts_q <= timeouts_q + 1'b1;
              oRemaining <= rem_dec;
              if (last_meas) begin
                oRunDone <= 1'b1;
                state    <= S_IDLE;
                {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_IDLE);
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= S_GAP;
                {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_GAP);
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
          S_STORE: begin
            if (oFull && !pop) oOverflow <= 1'b1;
            oRemaining <= rem_dec;
            if (last_meas) begin
              oRunDone <= 1'b1;
              state    <= S_IDLE;
              {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_IDLE);
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
              {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_GAP);
            end
          end
          default: begin
            state <= S_IDLE;
            {oTdcEnable, oTdcRst, oBusy} <= drive_for(S_IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_sequencer.sv
// Testbench for tdc_sequencer: table-driven runs, hand-written corner cases
// and randomized runs checked against a queue-based reference model.
module tb_tdc_sequencer;
  localparam int DATA_W = 8, CNT_W = 16, FIFO_AW = 2, GAP_CYC = 4, TMO_W = 4;
  localparam int DEPTH = 4;
  localparam int GUARD = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, tdc_done = 1'b0, rd = 1'b0;
  logic [CNT_W-1:0] num_meas = '0;
  logic [DATA_W-1:0] tdc_data = '0;
  logic tdc_en, tdc_rst, empty, full, busy, run_done, ovf;
  logic [DATA_W-1:0] o_data;
  logic [FIFO_AW:0] level;
  logic [CNT_W-1:0] remaining, timeouts;

  always #5 clk = ~clk;

  tdc_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_AW(FIFO_AW),
                  .GAP_CYC(GAP_CYC), .TMO_W(TMO_W)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iAbort(abort), .iNumMeas(num_meas),
    .iTdcData(tdc_data), .iTdcDone(tdc_done), .oTdcEnable(tdc_en), .oTdcRst(tdc_rst),
    .iRd(rd), .oData(o_data), .oEmpty(empty), .oFull(full), .oLevel(level),
    .oBusy(busy), .oRunDone(run_done), .oOverflow(ovf), .oRemaining(remaining),
    .oTimeouts(timeouts));

  int total = 0;
  int bad = 0;

  // Reference model: FIFO as a queue plus run-level bookkeeping.
  logic [DATA_W-1:0] mq[$];
  bit m_ovf = 0, m_busy = 0, m_rundone = 0, store_due = 0;
  logic [DATA_W-1:0] store_data = '0;
  int m_rem = 0;
  int rundone_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_busy = 0; m_rundone = 0; store_due = 0; m_rem = 0;
  endtask

  // One clock: drive after a negedge, apply the spec rules at the posedge,
  // compare at the following negedge.
  task automatic step(input bit r, input bit dn, input logic [DATA_W-1:0] d,
                      input bit ab, input bit st, input int n);
    bit accept;
    bit popped;
    accept = dn && (tdc_en === 1'b1) && !ab;
    rd = r; tdc_done = dn; tdc_data = d; abort = ab; start = st;
    num_meas = CNT_W'(n);
    @(posedge clk);
    m_rundone = 0;
    popped = r && (mq.size() > 0);
    if (popped) void'(mq.pop_front());
    if (ab && m_busy) begin
      m_busy = 0;
      store_due = 0;
    end else if (store_due) begin
      if (mq.size() < DEPTH) mq.push_back(store_data);
      else m_ovf = 1;
      if (m_rem > 0) m_rem--;
      if (m_rem == 0) begin m_busy = 0; m_rundone = 1; end
      store_due = 0;
    end else if (st && !m_busy) begin
      if (n == 0) m_rundone = 1;
      else begin m_busy = 1; m_rem = n; m_ovf = 0; end
    end
    if (accept) begin store_due = 1; store_data = d; end
    @(negedge clk);
    rd = 0; tdc_done = 0; abort = 0; start = 0;
    if (run_done === 1'b1) rundone_cnt++;
    check("level", level, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    if (mq.size() > 0) check("head", o_data, mq[0]);
    check("overflow", ovf, m_ovf);
    check("remaining", remaining, m_rem);
    check("run_done", run_done, m_rundone);
    check("busy", busy, m_busy);
    check("timeouts", timeouts, 0);
  endtask

  task automatic idle_step();
    step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic wait_en(output int cyc);
    cyc = 0;
    while (tdc_en !== 1'b1 && cyc < 100) begin idle_step(); cyc++; end
    if (cyc >= 100) check("wait_en_bound", 1, 0);
  endtask

  // Full run: core answers dly cycles after each enable rise with base*(k+1).
  task automatic run(input int n, input int dly, input int rd_pct, input int stale_pct,
                     input logic [DATA_W-1:0] base);
    int k = 0, wcnt = 0, guard = 0;
    step(0, 0, '0, 0, 1, n);
    while (m_busy && guard < GUARD) begin
      bit r, dn;
      logic [DATA_W-1:0] d;
      r = ($urandom_range(99) < rd_pct);
      dn = 0;
      d = DATA_W'(int'(base) * (k + 1));
      if (tdc_en === 1'b1) begin
        if (wcnt >= dly) begin dn = 1; k++; wcnt = 0; end
        else wcnt++;
      end else begin
        wcnt = 0;
        dn = ($urandom_range(99) < stale_pct);
        d = 8'hEE;
      end
      step(r, dn, d, 0, 0, 0);
      guard++;
    end
    if (guard >= GUARD) check("run_bound", 1, 0);
  endtask

  task automatic drain();
    int g = 0;
    while (mq.size() > 0 && g < 64) begin step(1, 0, '0, 0, 0, 0); g++; end
  endtask

  typedef struct {
    int n;
    int dly;
    logic [DATA_W-1:0] base;
    int exp_level;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c, rd0;
    vecs[0] = '{n: 3, dly: 5, base: 8'h11, exp_level: 3, exp_ovf: 0};
    vecs[1] = '{n: 6, dly: 2, base: 8'h10, exp_level: 4, exp_ovf: 1};
    vecs[2] = '{n: 4, dly: 0, base: 8'h05, exp_level: 4, exp_ovf: 0};
    vecs[3] = '{n: 1, dly: 3, base: 8'h40, exp_level: 1, exp_ovf: 0};
    vecs[4] = '{n: 5, dly: 1, base: 8'h03, exp_level: 4, exp_ovf: 1};
    vecs[5] = '{n: 2, dly: 7, base: 8'h21, exp_level: 2, exp_ovf: 0};

    // Reset values.
    #12;
    check("rst_enable", tdc_en, 0);
    check("rst_tdc_rst", tdc_rst, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_run_done", run_done, 0);
    check("rst_overflow", ovf, 0);
    check("rst_remaining", remaining, 0);
    check("rst_timeouts", timeouts, 0);
    @(negedge clk);
    rst = 0;
    idle_step();

    // Table-driven runs with no pops; FIFO drained between entries.
    for (int i = 0; i < 6; i++) begin
      rd0 = rundone_cnt;
      run(vecs[i].n, vecs[i].dly, 0, 20, vecs[i].base);
      idle_step();
      check("vec_level", level, vecs[i].exp_level);
      check("vec_full", full, vecs[i].exp_level == DEPTH);
      check("vec_overflow", ovf, vecs[i].exp_ovf);
      check("vec_remaining", remaining, 0);
      check("vec_run_done_cnt", rundone_cnt - rd0, 1);
      for (int k = 0; k < vecs[i].exp_level; k++) begin
        check("vec_word", o_data, DATA_W'(int'(vecs[i].base) * (k + 1)));
        step(1, 0, '0, 0, 0, 0);
      end
      check("vec_drained", empty, 1);
    end

    // Zero-measurement start: run_done pulse, stays idle.
    rd0 = rundone_cnt;
    step(0, 0, '0, 0, 1, 0);
    check("zero_run_done", rundone_cnt - rd0, 1);
    check("zero_busy", busy, 0);

    // Start-to-enable and re-arm latency.
    step(0, 0, '0, 0, 1, 2);
    wait_en(c);
    check("start_to_enable", c, GAP_CYC + 1);
    check("wait_tdc_rst", tdc_rst, 0);
    step(0, 1, 8'hA5, 0, 0, 0);
    check("store_enable_low", tdc_en, 0);
    idle_step();
    check("empty_after_store", empty, 0);
    check("gap_tdc_rst", tdc_rst, 1);
    wait_en(c);
    check("rearm", c + 1, GAP_CYC + 2);
    step(0, 1, 8'h5A, 0, 0, 0);
    idle_step();
    drain();

    // Abort together with done during measurement 2 of 4.
    rd0 = rundone_cnt;
    step(0, 0, '0, 0, 1, 4);
    wait_en(c);
    step(0, 1, 8'h61, 0, 0, 0);
    wait_en(c);
    step(0, 1, 8'h62, 1, 0, 0);
    check("abort_enable", tdc_en, 0);
    check("abort_tdc_rst", tdc_rst, 1);
    check("abort_level", level, 1);
    check("abort_remaining", remaining, 3);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h77, 0, 0, 0);
    check("abort_no_run_done", rundone_cnt - rd0, 0);
    check("abort_head", o_data, 8'h61);
    drain();

    // Full FIFO with a pop in the STORE cycle: word appended, no overflow.
    run(4, 1, 0, 0, 8'h08);
    step(0, 0, '0, 0, 1, 1);
    wait_en(c);
    step(0, 1, 8'h99, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    check("fullpop_level", level, 4);
    check("fullpop_overflow", ovf, 0);
    for (int k = 0; k < 3; k++) step(1, 0, '0, 0, 0, 0);
    check("fullpop_tail", o_data, 8'h99);
    drain();

    // Randomized runs with random pops and stale done pulses.
    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(1, 7)), int'($urandom_range(0, 6)), 30, 20,
          DATA_W'($urandom_range(1, 255)));
      idle_step();
    end
    drain();

    // Asynchronous reset mid-WAIT with two words in the FIFO.
    step(0, 0, '0, 0, 1, 3);
    wait_en(c);
    step(0, 1, 8'h31, 0, 0, 0);
    wait_en(c);
    step(0, 1, 8'h32, 0, 0, 0);
    wait_en(c);
    check("pre_reset_level", level, 2);
    #2 rst = 1;
    #1;
    check("arst_enable", tdc_en, 0);
    check("arst_tdc_rst", tdc_rst, 1);
    check("arst_empty", empty, 1);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    check("arst_remaining", remaining, 0);
    check("arst_overflow", ovf, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle_step();
    idle_step();

`ifdef TDC_TIMEOUT_EN
    begin
      int en_cyc = 0, rdn = 0;
      start = 1; num_meas = 2;
      @(posedge clk);
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 120; i++) begin
        if (tdc_en === 1'b1) en_cyc++;
        if (run_done === 1'b1) rdn++;
        @(negedge clk);
      end
      check("tmo_wait_cycles", en_cyc, 2 * ((1 << TMO_W) - 1));
      check("tmo_count", timeouts, 2);
      check("tmo_run_done", rdn, 1);
      check("tmo_empty", empty, 1);
      check("tmo_remaining", remaining, 0);
      check("tmo_busy", busy, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
